// File: rtl/alu_result_buffer.sv
// ---------------------------------------------------------------------------
// alu_result_buffer
//
// Execute-to-writeback buffer that sits directly behind the 3-bit-control
// ALU. Each accepted beat is captured together with its destination tag, a
// qualified write enable and zero/negative/illegal flags, then held in a
// 2-entry circular buffer. in_ready depends only on registered occupancy
// (and reset), so a writeback stall never creates a combinational path
// back into execute.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   flush             discard all buffered entries and the current input beat
//   in_valid/in_ready upstream handshake
//   in_result         ALU result
//   in_control        ALU control code that produced in_result
//   in_rd, in_wr_en   destination register index and raw write enable
//   out_valid/out_ready downstream handshake
//   out_result, out_rd, out_wr_en, out_zero, out_neg, out_illegal
//                     head entry payload, driven straight from registers
//   out_count         occupancy 0..2
// ---------------------------------------------------------------------------
module alu_result_buffer #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_result,
    input  logic [2:0]                in_control,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic                      in_wr_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_result,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic                      out_wr_en,
    output logic                      out_zero,
    output logic                      out_neg,
    output logic                      out_illegal,
    output logic [1:0]                out_count
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     result;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      wr_en;
        logic                      zero;
        logic                      neg;
        logic                      illegal;
    } entry_t;

    // Control codes 110 and 111 are not defined for the ALU.
    function automatic logic is_illegal(input logic [2:0] control);
        return control[2] & control[1];
    endfunction

    // Register 0 is hard-wired and illegal results must never retire.
    function automatic logic qualify_wr_en(input logic                      wr_en,
                                           input logic [REG_ADDR_WIDTH-1:0] rd,
                                           input logic                      illegal);
        return wr_en && (rd != '0) && !illegal;
    endfunction

    logic [1:0] count;
    logic       wr_ptr;
    logic       rd_ptr;
    entry_t     mem [2];
    entry_t     head;
    entry_t     cap;
    logic       push;
    logic       pop;
    logic       load_in;
    logic       load_mem;

    assign in_ready  = (count != 2'd2) && !reset;
    assign out_valid = (count != 2'd0);
    assign out_count = count;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        cap         = '0;
        cap.result  = in_result;
        cap.rd      = in_rd;
        cap.illegal = is_illegal(in_control);
        cap.zero    = (in_result == '0);
        cap.neg     = in_result[DATA_WIDTH-1];
        cap.wr_en   = qualify_wr_en(in_wr_en, in_rd, cap.illegal);
    end

    // The head register takes the incoming beat when that beat becomes the
    // head on this edge (empty buffer, or one entry being replaced); it takes
    // the second stored entry when a full buffer pops. Otherwise it holds,
    // which keeps the payload stable under stall and leaves the last popped
    // beat visible once the buffer drains.
    assign load_in  = push && ((count == 2'd0) || ((count == 2'd1) && pop));
    assign load_mem = pop && (count == 2'd2);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cap;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            head   <= '0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (load_in) begin
                head <= cap;
            end else if (load_mem) begin
                head <= mem[~rd_ptr];
            end
        end
    end

    assign out_result  = head.result;
    assign out_rd      = head.rd;
    assign out_wr_en   = head.wr_en;
    assign out_zero    = head.zero;
    assign out_neg     = head.neg;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_alu_result_buffer.sv
// ---------------------------------------------------------------------------
// Testbench for alu_result_buffer: a queue-based reference model updated on
// each rising edge, a compare process on the falling edge, and directed
// stimulus with hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_alu_result_buffer;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_result = '0;
    logic [2:0]    in_control = 3'b000;
    logic [AW-1:0] in_rd = '0;
    logic          in_wr_en = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_result;
    logic [AW-1:0] out_rd;
    logic          out_wr_en;
    logic          out_zero;
    logic          out_neg;
    logic          out_illegal;
    logic [1:0]    out_count;

    alu_result_buffer #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_control(in_control),
        .in_rd(in_rd), .in_wr_en(in_wr_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_wr_en(out_wr_en),
        .out_zero(out_zero), .out_neg(out_neg), .out_illegal(out_illegal),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] result;
        logic [AW-1:0] rd;
        logic          wr_en;
        logic          zero;
        logic          neg;
        logic          illegal;
    } beat_t;

    beat_t q[$];
    beat_t last;
    bit    started = 0;
    bit    payload_known = 0;

    function automatic beat_t make_beat(input logic [DW-1:0] r, input logic [2:0] c,
                                        input logic [AW-1:0] rd, input logic we);
        beat_t b;
        b.result  = r;
        b.rd      = rd;
        b.illegal = (c == 3'b110) || (c == 3'b111);
        b.zero    = (r == 0);
        b.neg     = r[DW-1];
        b.wr_en   = we && (rd != 0) && !b.illegal;
        return b;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            last          = '{default: '0};
            payload_known = 1;
            started       = 1;
        end else if (flush) begin
            q.delete();
            payload_known = 0;
        end else begin
            bit m_push;
            bit m_pop;
            beat_t nb;
            m_push = in_valid && (q.size() < 2);
            m_pop  = (q.size() > 0) && out_ready;
            nb     = make_beat(in_result, in_control, in_rd, in_wr_en);
            if (m_pop) last = q.pop_front();
            if (m_push) q.push_back(nb);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("in_ready", in_ready, (q.size() < 2) && !reset);
            check("out_valid", out_valid, q.size() != 0);
            check("out_count", out_count, q.size());
            if (q.size() != 0 || payload_known) begin
                beat_t e;
                e = (q.size() != 0) ? q[0] : last;
                check("out_result", out_result, e.result);
                check("out_rd", out_rd, e.rd);
                check("out_wr_en", out_wr_en, e.wr_en);
                check("out_zero", out_zero, e.zero);
                check("out_neg", out_neg, e.neg);
                check("out_illegal", out_illegal, e.illegal);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle(input logic v, input logic [DW-1:0] r, input logic [2:0] c,
                         input logic [AW-1:0] rd, input logic we, input logic rdy);
        in_valid   = v;
        in_result  = r;
        in_control = c;
        in_rd      = rd;
        in_wr_en   = we;
        out_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, '0, 3'b000, '0, 1'b0, rdy);
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        idle(1'b0);
        idle(1'b0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_count", out_count, 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Single beat
        cycle(1'b1, 32'h0000_0005, 3'b000, 5'd3, 1'b1, 1'b1);
        check("single_valid", out_valid, 1);
        check("single_result", out_result, 32'h5);
        check("single_rd", out_rd, 3);
        check("single_wr_en", out_wr_en, 1);
        check("single_zero", out_zero, 0);
        check("single_neg", out_neg, 0);
        idle(1'b1);
        check("single_drained", out_count, 0);

        // Backpressure
        cycle(1'b1, 32'h11, 3'b000, 5'd1, 1'b1, 1'b0);
        cycle(1'b1, 32'h22, 3'b000, 5'd2, 1'b1, 1'b0);
        check("bp_full_ready", in_ready, 0);
        check("bp_full_count", out_count, 2);
        cycle(1'b1, 32'h33, 3'b000, 5'd3, 1'b1, 1'b0);
        check("bp_33_rejected_count", out_count, 2);
        check("bp_head_stable", out_result, 32'h11);
        idle(1'b1);
        check("bp_second", out_result, 32'h22);
        idle(1'b1);
        check("bp_empty", out_valid, 0);
        check("bp_ready_back", in_ready, 1);

        // Streaming with wrap-around
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, DW'(i), 3'b010, AW'(i), 1'b1, 1'b1);
            check("stream_head", out_result, i);
            check("stream_count_le1", out_count <= 2'd1, 1);
        end
        idle(1'b1);

        // Flags and write-enable qualification
        cycle(1'b1, 32'h0000_0000, 3'b000, 5'd7, 1'b1, 1'b1);
        check("flag_zero", out_zero, 1);
        cycle(1'b1, 32'h8000_0000, 3'b001, 5'd8, 1'b1, 1'b1);
        check("flag_neg", out_neg, 1);
        check("flag_neg_zero", out_zero, 0);
        cycle(1'b1, 32'h1234, 3'b110, 5'd4, 1'b1, 1'b1);
        check("flag_illegal", out_illegal, 1);
        check("illegal_wr_en", out_wr_en, 0);
        cycle(1'b1, 32'h55, 3'b111, 5'd4, 1'b1, 1'b1);
        check("flag_illegal_111", out_illegal, 1);
        cycle(1'b1, 32'h66, 3'b000, 5'd0, 1'b1, 1'b1);
        check("rd0_wr_en", out_wr_en, 0);
        check("rd0_legal", out_illegal, 0);
        idle(1'b1);
        check("last_popped_hold", out_result, 32'h66);

        // Simultaneous push and pop at count=1
        cycle(1'b1, 32'hAA, 3'b000, 5'd9, 1'b1, 1'b0);
        check("pp_count1", out_count, 1);
        cycle(1'b1, 32'hBB, 3'b000, 5'd10, 1'b1, 1'b1);
        check("pp_count_same", out_count, 1);
        check("pp_new_head", out_result, 32'hBB);
        idle(1'b1);

        // Flush at count=2 with an input beat offered
        cycle(1'b1, 32'hC0, 3'b000, 5'd1, 1'b1, 1'b0);
        cycle(1'b1, 32'hD0, 3'b000, 5'd2, 1'b1, 1'b0);
        check("fl_full", out_count, 2);
        flush = 1'b1;
        cycle(1'b1, 32'hE0, 3'b000, 5'd3, 1'b1, 1'b1);
        flush = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_count", out_count, 0);
        idle(1'b1);
        idle(1'b1);
        check("fl_no_ghost", out_valid, 0);

        // Flush while pushing into an empty buffer drops the beat
        flush = 1'b1;
        cycle(1'b1, 32'hF0, 3'b000, 5'd3, 1'b1, 1'b1);
        flush = 1'b0;
        check("fl_empty_drop", out_count, 0);

        // Reset while full and stalled
        cycle(1'b1, 32'h101, 3'b000, 5'd5, 1'b1, 1'b0);
        cycle(1'b1, 32'h202, 3'b000, 5'd6, 1'b1, 1'b0);
        reset = 1'b1;
        idle(1'b0);
        check("mr_valid", out_valid, 0);
        check("mr_count", out_count, 0);
        check("mr_result", out_result, 0);
        check("mr_rd", out_rd, 0);
        check("mr_in_ready", in_ready, 0);
        reset = 1'b0;
        idle(1'b1);
        check("mr_ready_back", in_ready, 1);
        idle(1'b1);
        check("mr_no_stale", out_valid, 0);

        // Reset wins over flush
        cycle(1'b1, 32'h303, 3'b000, 5'd5, 1'b1, 1'b0);
        reset = 1'b1;
        flush = 1'b1;
        idle(1'b0);
        flush = 1'b0;
        check("rf_result", out_result, 0);
        reset = 1'b0;
        idle(1'b1);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Execute-to-writeback stage directly downstream of the 3-bit-control ALU.
- Captures each ALU result with its destination register tag and write enable, and derives zero/negative/illegal flags.
- Holds results in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Lets the writeback/memory stage stall without a combinational ready path back into execute.

Parameters:
- DATA_WIDTH, 32, width of ALU result and buffered data.
- REG_ADDR_WIDTH, 5, width of destination register index.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of all buffered entries and the current input beat.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  buffer can accept a beat this cycle.
- in_result  input  DATA_WIDTH  ALU Result.
- in_control  input  3  ALU control code that produced in_result.
- in_rd  input  REG_ADDR_WIDTH  destination register index.
- in_wr_en  input  1  instruction writes a register.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts head entry.
- out_result  output  DATA_WIDTH  head result.
- out_rd  output  REG_ADDR_WIDTH  head destination index.
- out_wr_en  output  1  qualified write enable of head.
- out_zero  output  1  head result equals 0.
- out_neg  output  1  MSB of head result.
- out_illegal  output  1  head was produced by an undefined control code (110/111).
- out_count  output  2  occupancy, 0..2.

Behaviour:
- Reset (reset=1 at a clock edge):
  - count=0; out_valid=0; out_result=0; out_rd=0; out_wr_en=0; out_zero=0; out_neg=0; out_illegal=0; out_count=0.
  - in_ready=0 while reset is high; in_ready=1 from the first cycle after reset is released.
- Reset mid-operation: all entries are lost, with no partial beat retained.
- Push: in_valid && in_ready && !flush.
- Pop: out_valid && out_ready && !flush.
- in_ready = (count<2) && !reset. It is a function of registered state only and never of out_ready.
- Storage: 2-entry circular buffer.
  - 1-bit write pointer and 1-bit read pointer, each wrapping 1->0.
  - Head entry drives all out_* payload ports directly from registers.
- Latency: a beat pushed at edge N is visible on out_* in cycle N+1 when the buffer was empty. There is no combinational bypass.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, with both pointers advancing.
  - count=2: in_ready=0, so no push; pop alone takes count to 1.
  - count=0: out_valid=0; out_ready is ignored.
- Flags, computed at capture and stored per entry:
  - zero = (in_result == 0).
  - neg = in_result[DATA_WIDTH-1].
  - illegal = (in_control == 3'b110 or 3'b111).
- Write-enable qualification, applied at capture: stored wr_en = in_wr_en && (in_rd != 0) && !illegal.
  - Register 0 is never written.
  - Illegal beats are still buffered and delivered so the downstream stage can flag them.
- Stall: while out_valid && !out_ready, every out_* payload port holds stable.
- Payload when out_valid=0: out_* payload ports drive the last popped values. Downstream must qualify with out_valid.
- Flush:
  - count=0, pointers=0, out_valid=0 on the next cycle.
  - Flush has priority over a simultaneous push and pop; the input beat is dropped.
- Reset priority: reset has priority over flush.
- No arithmetic on data; DATA_WIDTH bits pass unchanged.

Test Plan:
- Reset, then a single beat: in_result=0x0000_0005, in_rd=3, in_wr_en=1, in_control=000, out_ready=1 -> one cycle later out_valid=1, out_result=5, out_rd=3, out_wr_en=1, out_zero=0, out_neg=0; next cycle out_count=0.
- Backpressure: out_ready=0, push 0x11, 0x22, then offer 0x33 -> in_ready=0 after the second push, out_count=2, 0x33 not accepted; raise out_ready -> 0x11 then 0x22 are delivered in order and in_ready returns to 1.
- Streaming with wrap-around: 8 beats 0x1..0x8 back-to-back with out_ready=1 -> the 8 beats appear in order on consecutive cycles, out_count never exceeds 1, pointers wrap each other beat.
- Flags and qualification:
  - result 0x0000_0000 -> out_zero=1.
  - result 0x8000_0000 -> out_neg=1.
  - in_control=110, in_wr_en=1, in_rd=4 -> out_illegal=1, out_wr_en=0.
  - in_rd=0, in_wr_en=1 -> out_wr_en=0.
- Simultaneous push and pop at count=1 -> count stays 1 and the new head equals the pushed beat next cycle. Flush asserted with in_valid=1 at count=2 -> next cycle out_valid=0, out_count=0, and the flushed input beat never appears.
- Reset asserted while count=2 and stalled -> next cycle all outputs 0 and in_ready=0; after release in_ready=1 and no stale beat emerges.
